// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//   Steps through one of four address ranges of an external synchronous ROM
//   and shows each word on the LEDs. A tick divider paces the steps. A
//   debounced two-bit switch selects the pattern, and a new pattern takes
//   effect only at a tick boundary.
//
// Ports
//   clk_i     : system clock, all logic on the rising edge
//   rst_n     : asynchronous active-low reset
//   sw[1:0]   : raw, asynchronous, possibly bouncing pattern select
//   run       : 1 = advance on tick, 0 = hold the current step
//   rom_addr  : registered ROM address
//   rom_data  : ROM word for the current rom_addr
//   led       : registered displayed word
//   pat_idx   : currently active pattern
//   busy      : high while in LOAD or FETCH
module pattern_sequencer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 4,
  parameter int TICK_DIV     = 25000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [1:0]            sw,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] led,
  output logic [1:0]            pat_idx,
  output logic                  busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FETCH, SHOW} state_t;

  state_t          state;
  logic [1:0]      sync1, sync2;
  logic [1:0]      deb_sw;       // last accepted (debounced) switch value
  logic [1:0]      cand;         // value currently being timed for stability
  logic [DW-1:0]   deb_cnt;
  logic [DW-1:0]   cnt_inc;
  logic            accept;
  logic [1:0]      pend_sel;
  logic            pend_valid;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            enter_load;

  // First address of each pattern's range
  function automatic logic [ADDR_WIDTH-1:0] range_start(input logic [1:0] p);
    case (p)
      2'd0:    range_start = ADDR_WIDTH'(6'd0);
      2'd1:    range_start = ADDR_WIDTH'(6'd4);
      2'd2:    range_start = ADDR_WIDTH'(6'd12);
      default: range_start = ADDR_WIDTH'(6'd20);
    endcase
  endfunction

  // Last address (inclusive) of each pattern's range
  function automatic logic [ADDR_WIDTH-1:0] range_end(input logic [1:0] p);
    case (p)
      2'd0:    range_end = ADDR_WIDTH'(6'd3);
      2'd1:    range_end = ADDR_WIDTH'(6'd11);
      2'd2:    range_end = ADDR_WIDTH'(6'd19);
      default: range_end = ADDR_WIDTH'(6'd31);
    endcase
  endfunction

  // Two-flop synchroniser for the raw switch
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Stability count for a value that differs from the debounced one; a
  // stale cand with a zero count must not continue an old run.
  always_comb begin
    cnt_inc = DW'(1'b1);
    accept  = 1'b0;
    if (sync2 != deb_sw) begin
      if ((sync2 == cand) && (deb_cnt != '0)) begin
        cnt_inc = deb_cnt + DW'(1'b1);
      end else begin
        cnt_inc = DW'(1'b1);
      end
      accept = (cnt_inc >= DW'(DEBOUNCE_CYC));
    end else begin
      accept = 1'b0;
    end
  end

  // Debounce state
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      deb_sw  <= 2'b00;
      cand    <= 2'b00;
      deb_cnt <= '0;
    end else if (sync2 == deb_sw) begin
      deb_cnt <= '0;
    end else if (accept) begin
      deb_sw  <= sync2;
      deb_cnt <= '0;
    end else begin
      cand    <= sync2;
      deb_cnt <= cnt_inc;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // LOAD is entered from IDLE, or from SHOW when a pending switch is applied
  always_comb begin
    enter_load = 1'b0;
    if (state == IDLE) begin
      enter_load = 1'b1;
    end else if ((state == SHOW) && tick && run && pend_valid) begin
      enter_load = 1'b1;
    end else begin
      enter_load = 1'b0;
    end
  end

  // Free-running step divider, restarted on every LOAD entry
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (enter_load || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1'b1);
    end
  end

  // Sequencer FSM with registered outputs and pending-switch bookkeeping.
  // A fresh acceptance takes priority over clearing on apply so a newer
  // selection is never lost.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      led        <= '0;
      pat_idx    <= 2'b00;
      busy       <= 1'b0;
      pend_sel   <= 2'b00;
      pend_valid <= 1'b0;
    end else begin
      if (accept) begin
        pend_sel   <= sync2;
        pend_valid <= (sync2 != pat_idx);
      end else if ((state == SHOW) && tick && run && pend_valid) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          rom_addr <= range_start(pat_idx);
          state    <= FETCH;
          busy     <= 1'b1;
        end
        FETCH: begin
          led   <= rom_data;
          state <= SHOW;
          busy  <= 1'b0;
        end
        SHOW: begin
          if (tick && run) begin
            busy <= 1'b1;
            if (pend_valid) begin
              pat_idx <= pend_sel;
              state   <= LOAD;
            end else begin
              if (rom_addr == range_end(pat_idx)) begin
                rom_addr <= range_start(pat_idx);
              end else begin
                rom_addr <= rom_addr + ADDR_WIDTH'(1'b1);
              end
              state <= FETCH;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
